filter_coeff_sequencer: RTL

- Configuration controller for the 5-tap integer IIR filter used in the composite chroma/luma path.
- Holds a shadow bank of coefficients (b0..b4, a1..a4, a_precision, b_precision) written by the host.
- On commit, swaps the shadow bank into the active bank only at a video sync boundary, then flushes filter state and mutes output while the filter settles.
- Sits between the host register interface and the filter's coefficient/sample inputs.

---
 rtl/filter_coeff_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/filter_coeff_sequencer.sv
// Coefficient shadow/active bank controller for the 5-tap IIR filter.
// Optional: FILTER_PRECISION_CLAMP_EN clamps precision writes to 1..30.
//
// state  | meaning
// RUN    | normal pass-through, waiting for pending commit + sync
// FLUSH  | filter state cleared, zero input, output muted
// SETTLE | samples flowing again, output still muted
module filter_coeff_sequencer #(
  parameter int FLUSH_CYCLES      = 8,
  parameter int SETTLE_CYCLES     = 16,
  parameter int DEFAULT_PRECISION = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        sync,
  input  logic [31:0] sample_in,
  output logic [31:0] filter_in,
  output logic        filter_clear,
  output logic        mute,
  output logic        pending,
  output logic        busy,
  output logic [31:0] coef_b0,
  output logic [31:0] coef_b1,
  output logic [31:0] coef_b2,
  output logic [31:0] coef_b3,
  output logic [31:0] coef_b4,
  output logic [31:0] coef_a1,
  output logic [31:0] coef_a2,
  output logic [31:0] coef_a3,
  output logic [31:0] coef_a4,
  output logic [31:0] a_precision,
  output logic [31:0] b_precision
);

  typedef enum logic [1:0] {RUN, FLUSH, SETTLE} state_t;

  state_t      state, next_state;
  logic [15:0] count;
  logic        swap;
  logic [31:0] wr_value;
  logic [31:0] shadow [0:10];
  logic [31:0] active [0:10];

  function automatic logic [31:0] reset_value(input int idx);
    if (idx == 0) return 32'(1) <<< DEFAULT_PRECISION;
    if (idx >= 9) return 32'(DEFAULT_PRECISION);
    return 32'd0;
  endfunction

  always_comb begin
    wr_value = wr_data;
`ifdef FILTER_PRECISION_CLAMP_EN
    // Filter rounding uses shift-1, so a zero shift is never valid.
    if (wr_addr == 4'd9 || wr_addr == 4'd10) begin
      if ($signed(wr_data) < 32'sd1)       wr_value = 32'd1;
      else if ($signed(wr_data) > 32'sd30) wr_value = 32'd30;
    end
`endif
  end

  always_comb begin
    next_state = state;
    swap       = 1'b0;
    unique case (state)
      RUN:    if (pending && sync) begin
                next_state = FLUSH;
                swap       = 1'b1;
              end
      FLUSH:  if (count == 16'd0) next_state = SETTLE;
      SETTLE: if (count == 16'd0) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      count     <= 16'd0;
      pending   <= 1'b0;
      filter_in <= 32'd0;
    end else begin
      state <= next_state;
      if (swap)
        count <= 16'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && count == 16'd0)
        count <= 16'(SETTLE_CYCLES - 1);
      else if (count != 16'd0)
        count <= count - 16'd1;
      // A commit on the swap edge re-arms pending for the next sync.
      if (wr_en && wr_addr == 4'd11 && wr_data[0])
        pending <= 1'b1;
      else if (swap)
        pending <= 1'b0;
      filter_in <= (next_state == FLUSH) ? 32'd0 : sample_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) begin
        shadow[i] <= reset_value(i);
        active[i] <= reset_value(i);
      end
    end else begin
      if (wr_en && wr_addr <= 4'd10) shadow[wr_addr] <= wr_value;
      if (swap) active <= shadow;
    end
  end

  assign filter_clear = (state == FLUSH);
  assign mute         = (state != RUN);
  assign busy         = (state != RUN);

  assign coef_b0     = active[0];
  assign coef_b1     = active[1];
  assign coef_b2     = active[2];
  assign coef_b3     = active[3];
  assign coef_b4     = active[4];
  assign coef_a1     = active[5];
  assign coef_a2     = active[6];
  assign coef_a3     = active[7];
  assign coef_a4     = active[8];
  assign a_precision = active[9];
  assign b_precision = active[10];

endmodule
